sobel_stream_filter: RTL

- Streaming 3x3 Sobel edge detector for raster-scan greyscale pixels, placed between the UART receive path and the UART transmit path.
- Supersedes the single-shift-register window with true line buffers.
- Parametrised in pixel width and image size, with a selectable magnitude/threshold output mode.
- Valid/ready handshakes on both sides; one output pixel per input pixel.

---
 rtl/sobel_stream_filter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector over raster-scan pixels using two line buffers.
// Latency: 2 cycles from input accept to out_valid when there is no stall.
// Backpressure: the whole pipeline freezes while out_valid && !out_ready; in_ready follows out_ready combinationally.
module sobel_stream_filter #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAG_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW = DATA_W + 4;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [SW-1:0] SAT     = SW'((1 << DATA_W) - 1);

  // Line buffers: line_buf0 holds the previous line, line_buf1 the one before it.
  logic [DATA_W-1:0] line_buf0 [IMG_WIDTH];
  logic [DATA_W-1:0] line_buf1 [IMG_WIDTH];

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  logic              accept;
  logic              advance;

  // Stage 1: 3x3 window (row 0 = oldest line, column 0 = oldest column) plus position flags.
  logic [DATA_W-1:0] win [3][3];
  logic              s1_vld;
  logic              s1_border;
  logic              s1_last;

  // Stage 2: output register.
  logic              s2_vld;
  logic              s2_last;
  logic [DATA_W-1:0] s2_dat;

  logic signed [SW-1:0] p [3][3];
  logic signed [SW-1:0] gx;
  logic signed [SW-1:0] gy;
  logic [SW-1:0]        ax;
  logic [SW-1:0]        ay;
  logic [SW-1:0]        mag;
  logic [DATA_W-1:0]    pix_out;

  // Both stages move together, so one enable covers the whole pipeline.
  assign in_ready = !(s2_vld && !out_ready);
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  assign cur_col = in_sof ? '0 : col;
  assign cur_row = in_sof ? '0 : row;
  assign lb0_rd  = line_buf0[cur_col];
  assign lb1_rd  = line_buf1[cur_col];

  // Raster position counters, advanced on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_MAX) begin
        col <= '0;
        row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line buffer update: push the new pixel down one line at this column (contents need no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf1[cur_col] <= lb0_rd;
      line_buf0[cur_col] <= in_data;
    end
  end

  // Stage 1: shift the window left and load the new right-hand column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      s1_vld    <= 1'b0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
    end else if (advance) begin
      s1_vld <= accept;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= in_data;
        s1_border <= (cur_row < RW'(2)) || (cur_col < CW'(2));
        s1_last   <= (cur_row == ROW_MAX) && (cur_col == COL_MAX);
      end
    end
  end

  // Sobel gradients, magnitude and output mapping for the window held in stage 1.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = SW'(win[r][c]);
      end
    end
    gx  = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy  = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    ax  = gx[SW-1] ? -gx : gx;
    ay  = gy[SW-1] ? -gy : gy;
    mag = ax + ay;
    if (MAG_MODE == 1) begin
      pix_out = (mag > {4'b0000, threshold}) ? '1 : '0;
    end else begin
      pix_out = (mag > SAT) ? '1 : mag[DATA_W-1:0];
    end
    if (s1_border) begin
      pix_out = '0;
    end
  end

  // Stage 2: output register, held while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_dat  <= '0;
      s2_last <= 1'b0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_dat  <= pix_out;
      s2_last <= s1_vld && s1_last;
    end
  end

  assign out_valid  = s2_vld;
  assign out_data   = s2_dat;
  assign out_last   = s2_last;
  assign frame_done = s2_vld && out_ready && s2_last;

endmodule
